// File: rtl/multi_flexcounter.sv
// Multi-channel programmable-period counter. Each channel strobes once per period
// (periodic or one-shot) and all channels advance on one shared prescaler tick.
module multi_flexcounter #(
  parameter int CHANNELS   = 4,
  parameter int COUNTSIZE  = 10000,
  parameter int COUNTWIDTH = $clog2(COUNTSIZE),
  parameter int PRESCALE   = 1
) (
  input  logic                           clk,
  input  logic                           nRST,
  input  logic [CHANNELS-1:0]            enableCounter,
  input  logic [CHANNELS-1:0]            oneShot,
  input  logic [CHANNELS-1:0]            clear,
  input  logic [CHANNELS*COUNTWIDTH-1:0] maxCount,
  output logic [CHANNELS-1:0]            strobe,
  output logic [CHANNELS*COUNTWIDTH-1:0] count,
  output logic [CHANNELS-1:0]            done,
  output logic                           tick
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q, psc_d;

  always_comb begin
    psc_d = psc_q + PW'(1);
    if (psc_q == PS_LAST) psc_d = '0;
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) psc_q <= '0;
    else      psc_q <= psc_d;
  end

  // Gated by reset so that PRESCALE=1 still reports tick=0 while reset is held.
  assign tick = ~nRST & (psc_q == PS_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [COUNTWIDTH-1:0] cnt_q, cnt_d, max_c;
    logic                  stb_q, stb_d;
    logic                  done_q, done_d;
    logic                  hold, wrap;

    assign max_c = maxCount[g*COUNTWIDTH +: COUNTWIDTH];

    always_comb begin
      cnt_d  = cnt_q;
      stb_d  = 1'b0;
      done_d = done_q;
      hold   = ~enableCounter[g] | ~tick | (max_c == '0) | (oneShot[g] & done_q);
      // count >= maxCount-1, evaluated one bit wider so maxCount=0 cannot underflow.
      wrap   = ({1'b0, cnt_q} + (COUNTWIDTH+1)'(1)) >= {1'b0, max_c};
      if (clear[g]) begin
        cnt_d  = '0;
        done_d = 1'b0;
      end else if (!hold) begin
        if (wrap) begin
          cnt_d = '0;
          stb_d = 1'b1;
          if (oneShot[g]) done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + COUNTWIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge nRST) begin
      if (nRST) begin
        cnt_q  <= '0;
        stb_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        stb_q  <= stb_d;
        done_q <= done_d;
      end
    end

    assign count[g*COUNTWIDTH +: COUNTWIDTH] = cnt_q;
    assign strobe[g]                         = stb_q;
    assign done[g]                           = done_q;
  end

endmodule

// File: tb/tb_multi_flexcounter.sv
// Bench for multi_flexcounter: one PRESCALE=1 instance and one PRESCALE=4 instance
// sharing the same stimulus; expected {flag,strobe,count} words flow through exp_q.
module tb_multi_flexcounter;

  localparam int CH = 4;
  localparam int CS = 10000;
  localparam int CW = $clog2(CS);
  localparam int W  = CW + 2;

  logic            clk = 1'b0;
  logic            nRST;
  logic [CH-1:0]   en, os, clr;
  logic [CH*CW-1:0] maxc;
  logic [CH-1:0]   strobe_a, done_a, strobe_b, done_b;
  logic [CH*CW-1:0] count_a, count_b;
  logic            tick_a, tick_b;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, got_v;
  int n_cmp = 0;
  int n_err = 0;
  int edges = 0;

  multi_flexcounter #(.CHANNELS(CH), .COUNTSIZE(CS), .PRESCALE(1)) dut_a (
    .clk(clk), .nRST(nRST), .enableCounter(en), .oneShot(os), .clear(clr),
    .maxCount(maxc), .strobe(strobe_a), .count(count_a), .done(done_a), .tick(tick_a)
  );

  multi_flexcounter #(.CHANNELS(CH), .COUNTSIZE(CS), .PRESCALE(4)) dut_b (
    .clk(clk), .nRST(nRST), .enableCounter(en), .oneShot(os), .clear(clr),
    .maxCount(maxc), .strobe(strobe_b), .count(count_b), .done(done_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic set_max(input int ch, input int val);
    maxc[ch*CW +: CW] = CW'(val);
  endtask

  function automatic logic [CW-1:0] cnt_of(input logic [CH*CW-1:0] v, input int ch);
    return v[ch*CW +: CW];
  endfunction

  function automatic logic [W-1:0] pack(input bit f, input bit s, input int c);
    return {f, s, CW'(c)};
  endfunction

  task automatic test_reset();
    nRST = 1'b1; en = '0; os = '0; clr = '0; maxc = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (strobe_a !== '0) begin n_err++; $display("FAIL reset_strobe: got %h expected 0", strobe_a); end
    n_cmp++; if (count_a !== '0) begin n_err++; $display("FAIL reset_count: got %h expected 0", count_a); end
    n_cmp++; if (done_a !== '0) begin n_err++; $display("FAIL reset_done: got %h expected 0", done_a); end
    n_cmp++; if (tick_a !== 1'b0) begin n_err++; $display("FAIL reset_tick_a: got %b expected 0", tick_a); end
    n_cmp++; if (tick_b !== 1'b0) begin n_err++; $display("FAIL reset_tick_b: got %b expected 0", tick_b); end
    nRST = 1'b0;
    edges = 0;
    #1;
    n_cmp++; if (tick_a !== 1'b1) begin n_err++; $display("FAIL release_tick_a: got %b expected 1", tick_a); end
  endtask

  task automatic test_periodic();
    int pat_c[6] = '{1, 0, 1, 0, 1, 0};
    set_max(0, 2);
    en[0] = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(pack(1'b1, pat_c[i] == 0, pat_c[i]));
    for (int i = 0; i < 6; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {tick_a, strobe_a[0], cnt_of(count_a, 0)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL periodic[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
    en[0] = 1'b0; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    n_cmp++; if (cnt_of(count_a, 0) !== '0) begin n_err++; $display("FAIL periodic_clear: got %0d expected 0", cnt_of(count_a, 0)); end
  endtask

  task automatic test_oneshot();
    os[1] = 1'b1; set_max(1, 3); en[1] = 1'b1;
    exp_q.push_back(pack(0, 0, 1)); exp_q.push_back(pack(0, 0, 2));
    exp_q.push_back(pack(1, 1, 0));
    repeat (3) exp_q.push_back(pack(1, 0, 0));
    for (int i = 0; i < 6; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[1], strobe_a[1], cnt_of(count_a, 1)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL oneshot[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
    clr[1] = 1'b1;
    exp_q.push_back(pack(0, 0, 0));
    step();
    clr[1] = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {done_a[1], strobe_a[1], cnt_of(count_a, 1)};
    n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL oneshot_clear: got %h expected %h", got_v, exp_v); end
    exp_q.push_back(pack(0, 0, 1)); exp_q.push_back(pack(0, 0, 2));
    exp_q.push_back(pack(1, 1, 0)); exp_q.push_back(pack(1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[1], strobe_a[1], cnt_of(count_a, 1)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL oneshot_rearm[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_prescale();
    int mcnt = 0;
    bit ms;
    bit tk;
    int first_stb = -1;
    int second_stb = -1;
    set_max(2, 5);
    en[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tk = (edges % 4) == 3;
      ms = 1'b0;
      if (tk) begin
        if (mcnt + 1 >= 5) begin mcnt = 0; ms = 1'b1; end
        else mcnt = mcnt + 1;
      end
      exp_q.push_back(pack(((edges + 1) % 4) == 3, ms, mcnt));
      step();
      exp_v = exp_q.pop_front();
      got_v = {tick_b, strobe_b[2], cnt_of(count_b, 2)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL prescale[%0d]: got %h expected %h", i, got_v, exp_v); end
      if (strobe_b[2] === 1'b1) begin
        if (first_stb < 0) first_stb = edges;
        else if (second_stb < 0) second_stb = edges;
      end
    end
    n_cmp++;
    if (second_stb - first_stb != 20 || first_stb < 0) begin
      n_err++; $display("FAIL prescale_period: got %0d expected 20", second_stb - first_stb);
    end
    en[2] = 1'b0;
  endtask

  task automatic test_maxcount_change();
    set_max(3, 10); en[3] = 1'b1;
    repeat (7) step();
    n_cmp++; if (cnt_of(count_a, 3) !== CW'(7)) begin n_err++; $display("FAIL mc_pre: got %0d expected 7", cnt_of(count_a, 3)); end
    set_max(3, 4);
    exp_q.push_back(pack(0, 1, 0)); exp_q.push_back(pack(0, 0, 1));
    exp_q.push_back(pack(0, 0, 2)); exp_q.push_back(pack(0, 0, 3));
    exp_q.push_back(pack(0, 1, 0)); exp_q.push_back(pack(0, 0, 1));
    for (int i = 0; i < 6; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[3], strobe_a[3], cnt_of(count_a, 3)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL mc_lower[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
    set_max(3, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pack(0, 0, 1));
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[3], strobe_a[3], cnt_of(count_a, 3)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL mc_zero[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
    en[3] = 1'b0;
  endtask

  task automatic test_clear_wrap();
    int    n_st = 9;
    bit    c_s[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int    c_c[9]  = '{1, 2, 0, 1, 1, 1, 1, 2, 0};
    bit    c_en[9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
    bit    c_cl[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
    set_max(0, 3);
    for (int i = 0; i < n_st; i++) begin
      en[0] = c_en[i]; clr[0] = c_cl[i];
      exp_q.push_back(pack(0, c_s[i], c_c[i]));
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[0], strobe_a[0], cnt_of(count_a, 0)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL clear_hold[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
    en[0] = 1'b0; clr[0] = 1'b0;
  endtask

  task automatic test_mode_switch();
    exp_q.push_back(pack(1, 0, 0));
    step();
    exp_v = exp_q.pop_front();
    got_v = {done_a[1], strobe_a[1], cnt_of(count_a, 1)};
    n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL mode_held: got %h expected %h", got_v, exp_v); end
    os[1] = 1'b0;
    exp_q.push_back(pack(1, 0, 1)); exp_q.push_back(pack(1, 0, 2));
    exp_q.push_back(pack(1, 1, 0)); exp_q.push_back(pack(1, 0, 1));
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[1], strobe_a[1], cnt_of(count_a, 1)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL mode_periodic[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    set_max(0, 2); en[0] = 1'b1;
    step();
    #2 nRST = 1'b1;
    #1;
    n_cmp++; if (strobe_a !== '0) begin n_err++; $display("FAIL areset_strobe: got %h expected 0", strobe_a); end
    n_cmp++; if (count_a !== '0) begin n_err++; $display("FAIL areset_count: got %h expected 0", count_a); end
    n_cmp++; if (done_a !== '0) begin n_err++; $display("FAIL areset_done: got %h expected 0", done_a); end
    n_cmp++; if (tick_a !== 1'b0) begin n_err++; $display("FAIL areset_tick: got %b expected 0", tick_a); end
    n_cmp++; if (count_b !== '0) begin n_err++; $display("FAIL areset_count_b: got %h expected 0", count_b); end
    step();
    nRST = 1'b0;
    edges = 0;
    exp_q.push_back(pack(0, 0, 1)); exp_q.push_back(pack(0, 1, 0));
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {done_a[0], strobe_a[0], cnt_of(count_a, 0)};
      n_cmp++; if (got_v !== exp_v) begin n_err++; $display("FAIL areset_resume[%0d]: got %h expected %h", i, got_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_prescale();
    test_maxcount_change();
    test_clear_wrap();
    test_mode_switch();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
